byte_striping: RTL and testbench

//  Transmit-side lane splitter; sits directly upstream of the byte unstriping stage.

---
 rtl/byte_striping_if.sv | 41 ++++
 rtl/byte_striping.sv | 121 ++++++++++++
 tb/tb_byte_striping.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/byte_striping_if.sv
// byte_striping_if
//   Byte stream in, two striped lanes out, for the byte_striping lane splitter.
//   Signals:
//     data_in/valid_in            serial byte stream, one byte per clk_2f cycle at most
//     data_stripe_0/valid_stripe_0 lane 0 word (first byte of each pair)
//     data_stripe_1/valid_stripe_1 lane 1 word (second byte of each pair)
//     frame_phase                 free-running toggle; lanes load on edges where it is 1
//   Modports:
//     master  stream source / lane consumer
//     slave   the splitter itself
interface byte_striping_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] data_in;
   logic                  valid_in;
   logic [DATA_WIDTH-1:0] data_stripe_0;
   logic [DATA_WIDTH-1:0] data_stripe_1;
   logic                  valid_stripe_0;
   logic                  valid_stripe_1;
   logic                  frame_phase;

   modport master (
      output data_in,
      output valid_in,
      input  data_stripe_0,
      input  data_stripe_1,
      input  valid_stripe_0,
      input  valid_stripe_1,
      input  frame_phase
   );

   modport slave (
      input  data_in,
      input  valid_in,
      output data_stripe_0,
      output data_stripe_1,
      output valid_stripe_0,
      output valid_stripe_1,
      output frame_phase
   );
endinterface

// File: rtl/byte_striping.sv
// byte_striping
//   Transmit-side lane splitter. Bytes arriving on the serial stream are paired;
//   the first byte of a pair goes to lane 0, the second to lane 1. Lane outputs
//   load only on clk_2f edges where frame_phase is 1, so each lane word is held
//   for two clk_2f cycles. A lone byte left waiting longer than TIMEOUT idle
//   cycles is flushed on lane 0 with lane 1 marked invalid.
//   Ports:
//     clk_2f   only clock, rising edge
//     reset_L  synchronous active-low reset
//     bus      byte_striping_if slave: data_in/valid_in in; stripes, valids,
//              frame_phase out
//   Parameters:
//     DATA_WIDTH  byte / lane word width
//     TIMEOUT     idle cycles before a lone byte is flushed (1..15)
module byte_striping #(
   parameter int DATA_WIDTH = 8,
   parameter int TIMEOUT    = 4
) (
   input logic            clk_2f,
   input logic            reset_L,
   byte_striping_if.slave bus
);

   localparam logic [3:0] IDLE_LIMIT = 4'(TIMEOUT);

   // half register: first byte of a pair waiting for its partner
   logic [DATA_WIDTH-1:0] half_q;
   logic                  half_full;
   logic [3:0]            idle_cnt;

   // pending pair waiting for the next draining edge
   logic [DATA_WIDTH-1:0] pend_d0;
   logic [DATA_WIDTH-1:0] pend_d1;
   logic                  pend_v0;
   logic                  pend_v1;

   logic                  frame_phase_q;
   logic [DATA_WIDTH-1:0] stripe_0_q;
   logic [DATA_WIDTH-1:0] stripe_1_q;
   logic                  valid_0_q;
   logic                  valid_1_q;

   logic                  pair_wr;
   logic                  flush_wr;
   logic                  pend_wr;
   logic [DATA_WIDTH-1:0] new_d1;

   // An incoming byte always beats a flush that would fire in the same cycle.
   assign pair_wr  = bus.valid_in & half_full;
   assign flush_wr = ~bus.valid_in & half_full & (idle_cnt == IDLE_LIMIT);
   assign pend_wr  = pair_wr | flush_wr;
   assign new_d1   = pair_wr ? bus.data_in : '0;

   always_ff @(posedge clk_2f) begin
      if (!reset_L) begin
         half_q        <= '0;
         half_full     <= 1'b0;
         idle_cnt      <= '0;
         pend_d0       <= '0;
         pend_d1       <= '0;
         pend_v0       <= 1'b0;
         pend_v1       <= 1'b0;
         frame_phase_q <= 1'b0;
         stripe_0_q    <= '0;
         stripe_1_q    <= '0;
         valid_0_q     <= 1'b0;
         valid_1_q     <= 1'b0;
      end else begin
         frame_phase_q <= ~frame_phase_q;

         if (bus.valid_in) begin
            idle_cnt <= '0;
            if (half_full) begin
               half_full <= 1'b0;
            end else begin
               half_q    <= bus.data_in;
               half_full <= 1'b1;
            end
         end else if (half_full) begin
            if (flush_wr) begin
               half_full <= 1'b0;
               idle_cnt  <= '0;
            end else if (idle_cnt != IDLE_LIMIT) begin
               idle_cnt <= idle_cnt + 4'd1;
            end
         end

         if (frame_phase_q) begin
            // Draining edge: a pair completed right now bypasses pending.
            if (pend_wr) begin
               stripe_0_q <= half_q;
               stripe_1_q <= new_d1;
               valid_0_q  <= 1'b1;
               valid_1_q  <= pair_wr;
            end else begin
               valid_0_q <= pend_v0;
               valid_1_q <= pend_v1;
               if (pend_v0) begin
                  stripe_0_q <= pend_d0;
                  stripe_1_q <= pend_d1;
               end
            end
            pend_v0 <= 1'b0;
            pend_v1 <= 1'b0;
         end else if (pend_wr) begin
            // Input rate never exceeds the drain rate, so pending is empty here.
            pend_d0 <= half_q;
            pend_d1 <= new_d1;
            pend_v0 <= 1'b1;
            pend_v1 <= pair_wr;
         end
      end
   end

   assign bus.frame_phase    = frame_phase_q;
   assign bus.data_stripe_0  = stripe_0_q;
   assign bus.data_stripe_1  = stripe_1_q;
   assign bus.valid_stripe_0 = valid_0_q;
   assign bus.valid_stripe_1 = valid_1_q;

endmodule

// File: tb/tb_byte_striping.sv
// tb_byte_striping
//   Directed and randomized stimulus for byte_striping, checked cycle by cycle
//   against a queue-based reference model: bytes are paired in arrival order,
//   finished lane words go into a FIFO, and a word leaves the FIFO on every
//   odd clock edge counted from reset release.
module tb_byte_striping;
   localparam int DW = 8;
   localparam int TO = 4;

   typedef struct {
      logic [DW-1:0] d0;
      logic [DW-1:0] d1;
      logic          v0;
      logic          v1;
   } word_t;

   logic clk_2f  = 1'b0;
   logic reset_L = 1'b0;

   byte_striping_if #(.DATA_WIDTH(DW)) bus ();

   byte_striping #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
      .clk_2f  (clk_2f),
      .reset_L (reset_L),
      .bus     (bus)
   );

   always #5 clk_2f = ~clk_2f;

   int n_vec = 0;
   int n_err = 0;

   // reference model state
   word_t         fifo[$];
   logic [DW-1:0] m_first;
   bit            m_have   = 1'b0;
   int            m_idle   = 0;
   int            m_edges  = 0;
   logic [DW-1:0] e_d0     = '0;
   logic [DW-1:0] e_d1     = '0;
   logic          e_v0     = 1'b0;
   logic          e_v1     = 1'b0;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_edge(input logic rst_n, input logic v, input logic [DW-1:0] d);
      word_t w;
      if (!rst_n) begin
         fifo.delete();
         m_have  = 1'b0;
         m_idle  = 0;
         m_edges = 0;
         e_d0 = '0; e_d1 = '0; e_v0 = 1'b0; e_v1 = 1'b0;
         return;
      end
      if (v) begin
         if (m_have) begin
            w.d0 = m_first; w.d1 = d; w.v0 = 1'b1; w.v1 = 1'b1;
            fifo.push_back(w);
            m_have = 1'b0;
         end else begin
            m_first = d;
            m_have  = 1'b1;
         end
         m_idle = 0;
      end else if (m_have) begin
         if (m_idle == TO) begin
            w.d0 = m_first; w.d1 = '0; w.v0 = 1'b1; w.v1 = 1'b0;
            fifo.push_back(w);
            m_have = 1'b0;
            m_idle = 0;
         end else begin
            m_idle++;
         end
      end
      if (m_edges % 2 == 1) begin
         if (fifo.size() > 0) begin
            w = fifo.pop_front();
            e_d0 = w.d0; e_d1 = w.d1; e_v0 = w.v0; e_v1 = w.v1;
         end else begin
            e_v0 = 1'b0; e_v1 = 1'b0;
         end
      end
      m_edges++;
   endtask

   task automatic cyc(input logic v, input logic [DW-1:0] d, input logic rst_n);
      @(negedge clk_2f);
      check("frame_phase", {7'b0, bus.frame_phase}, {7'b0, 1'(m_edges % 2)});
      check("valid_stripe_0", {7'b0, bus.valid_stripe_0}, {7'b0, e_v0});
      check("valid_stripe_1", {7'b0, bus.valid_stripe_1}, {7'b0, e_v1});
      check("data_stripe_0", bus.data_stripe_0, e_d0);
      check("data_stripe_1", bus.data_stripe_1, e_d1);
      reset_L      = rst_n;
      bus.valid_in = v;
      bus.data_in  = d;
      #1;
      if (rst_n) begin
         n_vec++;
         assert (!(dut.pend_wr && dut.pend_v0 && !dut.frame_phase_q))
         else begin
            n_err++;
            $error("FAIL pending_overwrite: observed 1 expected 0 at %0t", $time);
         end
      end
      model_edge(rst_n, v, d);
   endtask

   task automatic put(input logic [DW-1:0] d);
      cyc(1'b1, d, 1'b1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 8'(i * 37), 1'b1);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 8'($urandom), 1'b0);
   endtask

   initial begin
      bus.valid_in = 1'b0;
      bus.data_in  = '0;

      // reset held with valid_in high
      do_reset(3);

      // back-to-back 0x01..0x08 from phase 0
      for (int i = 1; i <= 8; i++) put(8'(i));
      idle(4);

      // pair then idle, both start phases
      do_reset(1);
      put(8'hA0); put(8'hA1); idle(4);
      idle(1);
      put(8'hA0); put(8'hA1); idle(5);

      // lone byte flushed on lane 0
      put(8'h5A); idle(8);

      // partner arrives after 3 idle cycles, then on the 4th, then the 5th
      put(8'h11); idle(3); put(8'h22); idle(3);
      put(8'h11); idle(4); put(8'h22); idle(3);
      put(8'h11); idle(5); put(8'h22); idle(3);
      put(8'h11); idle(5); put(8'h22); idle(4);

      // reset while a byte is held
      put(8'h33);
      do_reset(1);
      put(8'h44); put(8'h55); idle(4);

      // randomized traffic with bursts and idle gaps of varying length
      for (int seg = 0; seg < 80; seg++) begin
         int len;
         int dens;
         len  = $urandom_range(1, 10);
         dens = $urandom_range(0, 3);
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) < dens + 1) put(8'($urandom));
            else idle(1);
         end
         if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 8));
         if ($urandom_range(0, 30) == 0) do_reset(1);
      end
      idle(10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
